riscv_branch_predictor: RTL



---
 rtl/riscv_bp_pkg.sv | 35 +++
 rtl/bp_counter_table.sv | 36 +++
 rtl/riscv_branch_predictor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/riscv_bp_pkg.sv
// Shared definitions for the RISC-V dynamic branch predictor.
//   - prediction mode constants
//   - 2-bit saturating counter encodings and their reset value
//   - saturating-increment helper used by the counters and the statistics
package riscv_bp_pkg;

  localparam int BP_STATIC_NT = 0;
  localparam int BP_STATIC_T  = 1;
  localparam int BP_BIMODAL   = 2;
  localparam int BP_GSHARE    = 3;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WEAK_NT;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

  // Next state of a 2-bit direction counter after a resolved branch.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [31:0] inc;
    inc = sat_inc({30'd0, ctr}, 32'd3);
    if (taken) return inc[1:0];
    return (ctr == CTR_STRONG_NT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of ENTRIES x 2-bit saturating direction counters.
//   clk, reset       : clock, asynchronous active-low reset (all counters -> 01)
//   rd_idx / rd_ctr  : asynchronous read port
//   wr_en, wr_idx,
//   wr_taken         : saturating update, applied on the rising edge
module bp_counter_table
  import riscv_bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  // NOTE: every counter sits in its own reset flop (not a RAM macro) because
  // the reset state 01 is architecturally visible through pred_taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (wr_en) begin
      // NOTE: non-blocking so the lookup in this cycle sees the old value.
      ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit counter table.
//   clk, reset        : clock, asynchronous active-low reset
//   pred_valid/pred_pc: fetch lookup (combinational result)
//   pred_hit/taken/target : BTB hit, predicted direction, predicted next PC
//   upd_*             : branch resolution from execute, applied on the edge
//   stat_*            : saturating lookup / update / mispredict counters
// MODE: 0 static NT, 1 static taken-on-hit, 2 bimodal, 3 gshare.
module riscv_branch_predictor
  import riscv_bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int MODE    = BP_BIMODAL,
  parameter int GHR_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic UPD_CTRS = (MODE == BP_BIMODAL) || (MODE == BP_GSHARE);

  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [XLEN-1:0]  btb_target [ENTRIES];
  logic [GHR_W-1:0] ghr;

  logic [IDX_W-1:0] pred_idx, upd_idx, pred_ctr_idx, upd_ctr_idx;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic [1:0]       pred_ctr;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign pred_tag = pred_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Byte-offset and upper PC bits take no part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  assign pred_hit    = btb_valid[pred_idx] && (btb_tag[pred_idx] == pred_tag);
  assign pred_target = pred_taken ? btb_target[pred_idx] : pred_pc + XLEN'(4);

  // NOTE: every output of this block gets a default first, so no latch forms.
  always_comb begin
    pred_ctr_idx = pred_idx;
    upd_ctr_idx  = upd_idx;
    pred_taken   = 1'b0;
    if (MODE == BP_GSHARE) begin
      pred_ctr_idx = pred_idx ^ IDX_W'(ghr);
      upd_ctr_idx  = upd_idx ^ IDX_W'(ghr);
    end
    case (MODE)
      BP_STATIC_T:          pred_taken = pred_hit;
      BP_BIMODAL, BP_GSHARE: pred_taken = pred_hit & pred_ctr[1];
      default:              pred_taken = 1'b0;
    endcase
  end

  bp_counter_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_ctr (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pred_ctr_idx),
    .rd_ctr   (pred_ctr),
    .wr_en    (upd_valid && UPD_CTRS),
    .wr_idx   (upd_ctr_idx),
    .wr_taken (upd_taken)
  );

  // BTB: only taken branches allocate; not-taken leaves the entry alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      btb_valid[upd_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (reset && upd_valid && upd_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
    end
  end

  // Global history, updated only with resolved outcomes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr <= '0;
    end else if (upd_valid && (MODE == BP_GSHARE)) begin
      ghr <= (ghr << 1) | GHR_W'(upd_taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups     <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pred_valid) stat_lookups <= sat_inc(stat_lookups, 32'hFFFF_FFFF);
      if (upd_valid)  stat_updates <= sat_inc(stat_updates, 32'hFFFF_FFFF);
      if (upd_valid && upd_mispredict)
        stat_mispredicts <= sat_inc(stat_mispredicts, 32'hFFFF_FFFF);
    end
  end

endmodule
